// File: rtl/fitness_pkg.sv
// Shared types, default widths and saturating-add helper for the fitness scoring stage.
package fitness_pkg;

    localparam int WORD_W = 16;
    localparam int LANES  = 4;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [LANES-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fsm_state_t;

    // Returns {clipped, result}; result is limited to 2^width-1 (width <= 63).
    function automatic logic [64:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] inc,
        input int          width
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return {1'b1, lim[63:0]};
        end
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/fitness_lane_metric.sv
// Per-lane distance between individual output and expected output.
// FITNESS_HAMMING_EN selects popcount(y ^ e); default is unsigned |y - e|.
module fitness_lane_metric
    import fitness_pkg::*;
(
    input  word_t y,
    input  word_t e,
    output word_t metric
);

`ifdef FITNESS_HAMMING_EN
    word_t diff_bits;

    always_comb begin
        diff_bits = y ^ e;
        metric    = '0;
        for (int i = 0; i < WORD_W; i++) begin
            metric = metric + WORD_W'(diff_bits[i]);
        end
    end
`else
    always_comb begin
        metric = (y >= e) ? (y - e) : (e - y);
    end
`endif

endmodule

// File: rtl/individual_fitness_accum.sv
// Scores an evolved individual over N vectors: 2-stage lane-metric pipeline into a
// saturating fitness accumulator. Optional Hamming metric via FITNESS_HAMMING_EN.
module individual_fitness_accum #(
    parameter int WORD_W = fitness_pkg::WORD_W,
    parameter int LANES  = fitness_pkg::LANES,
    parameter int ACC_W  = fitness_pkg::ACC_W,
    parameter int CNT_W  = fitness_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] y3,
    input  logic [WORD_W-1:0] y2,
    input  logic [WORD_W-1:0] y1,
    input  logic [WORD_W-1:0] y0,
    input  logic [WORD_W-1:0] e3,
    input  logic [WORD_W-1:0] e2,
    input  logic [WORD_W-1:0] e1,
    input  logic [WORD_W-1:0] e0,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  fitness,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              saturated
);
    import fitness_pkg::*;

    localparam int SUM_W = WORD_W + 2;

    fsm_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  n_lat_reg;
    logic [CNT_W-1:0]  acc_cnt_reg;
    logic              s1_valid_reg;
    lane_vec_t         s1_diff_reg;
    logic              s1_mis_reg;
    logic [ACC_W-1:0]  fitness_reg;
    logic [CNT_W-1:0]  mis_cnt_reg;
    logic              sat_reg;

    lane_vec_t         y_vec, e_vec, metric;
    logic              handshake;
    logic              start_acc;
    logic [SUM_W-1:0]  lane_sum;
    logic [64:0]       sat_res;
    logic [ACC_W-1:0]  fitness_next;
    logic              clip_next;

    assign y_vec = {y3, y2, y1, y0};
    assign e_vec = {e3, e2, e1, e0};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            fitness_lane_metric u_metric (
                .y      (y_vec[gi]),
                .e      (e_vec[gi]),
                .metric (metric[gi])
            );
        end
    endgenerate

    assign in_ready  = (state_reg == RUN) && (acc_cnt_reg < n_lat_reg);
    assign handshake = in_valid && in_ready;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);

    assign fitness      = fitness_reg;
    assign mismatch_cnt = mis_cnt_reg;
    assign saturated    = sat_reg;

    always_comb begin
        state_next = state_reg;
        start_acc  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = (n_samples == '0) ? DRAIN : RUN;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (handshake && (acc_cnt_reg + CNT_W'(1) == n_lat_reg)) begin
                    state_next = DRAIN;
                end
            end
            // Nothing enters stage 1 here, so whatever it holds commits on this edge.
            DRAIN:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(s1_diff_reg[i]);
        end
        sat_res      = sat_add(64'(fitness_reg), 64'(lane_sum), ACC_W);
        fitness_next = ACC_W'(sat_res);
        clip_next    = sat_res[64];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            n_lat_reg    <= '0;
            acc_cnt_reg  <= '0;
            s1_valid_reg <= 1'b0;
            s1_diff_reg  <= '0;
            s1_mis_reg   <= 1'b0;
            fitness_reg  <= '0;
            mis_cnt_reg  <= '0;
            sat_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s1_valid_reg <= handshake;
            if (handshake) begin
                s1_diff_reg <= metric;
                s1_mis_reg  <= (y_vec != e_vec);
                acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
            end
            // Stage 1 is always empty when a start is accepted, so the two never collide.
            if (start_acc) begin
                n_lat_reg   <= n_samples;
                acc_cnt_reg <= '0;
                fitness_reg <= '0;
                mis_cnt_reg <= '0;
                sat_reg     <= 1'b0;
            end else if (s1_valid_reg) begin
                fitness_reg <= fitness_next;
                if (clip_next) begin
                    sat_reg <= 1'b1;
                end
                if (s1_mis_reg && (mis_cnt_reg != '1)) begin
                    mis_cnt_reg <= mis_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

endmodule
